// File: rtl/mult_sequencer.sv
// Control/result stage for a shift-and-add multiplier: latches operands, sequences
// one load cycle and WIDTH shift cycles, then captures PQ with a one-cycle done pulse.
module mult_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic [2*WIDTH-1:0]   pq_in,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 load,
  output logic                 ctrl,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_SHIFT   = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_count;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_done;

  // Sequencer: operands latched on accepted start, count held at 0 outside SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_count <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_count == LAST_SHIFT) begin
            r_count <= '0;
            r_state <= S_CAPTURE;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          r_product <= pq_in;
          r_done    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_count <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore decode straight from the state register.
  assign load    = (r_state == S_LOAD);
  assign ctrl    = (r_state == S_SHIFT);
  assign busy    = (r_state != S_IDLE);
  assign a_out   = r_a;
  assign b_out   = r_b;
  assign product = r_product;
  assign done    = r_done;

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Control and result stage wrapped around the 4-bit shift-and-add multiplier datapath.
- Accepts an operand pair on a start request, drives the multiplier's `load` and `ctrl` pins through one load cycle and WIDTH shift cycles, then captures the multiplier's PQ output.
- Presents the registered product with a one-cycle `done` pulse.
- Upstream of the multiplier (operands, control) and downstream of it (product capture).

Parameters:
- WIDTH, 4, operand width; must match the multiplier. Product is 2*WIDTH bits.
- CNT_W, 3, shift-counter width; must satisfy 2^CNT_W > WIDTH-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiplication; sampled on rising edge.
- a_in  input  WIDTH  multiplicand, sampled with start.
- b_in  input  WIDTH  multiplier operand, sampled with start.
- pq_in  input  2*WIDTH  PQ output of the multiplier datapath.
- a_out  output  WIDTH  latched multiplicand to multiplier input A.
- b_out  output  WIDTH  latched operand to multiplier input B.
- load  output  1  multiplier load strobe.
- ctrl  output  1  multiplier shift/add enable.
- busy  output  1  operation in progress; start ignored while high.
- product  output  2*WIDTH  captured result, held until next capture.
- done  output  1  one-cycle pulse; product updated.

Behaviour:
- Reset: one clock, synchronous, active-high. Dominates all other inputs at any state, including mid-operation.
  - On reset: state=IDLE, count=0, a_out=0, b_out=0, product=0, done=0.
  - load, ctrl and busy decode to 0.
- State machine (Moore). load, ctrl and busy decode from the state register only, never from inputs.
  - IDLE: load=0, ctrl=0, busy=0.
    - start=1 at an edge: a_out<=a_in, b_out<=b_in, go to LOAD.
    - Otherwise stay in IDLE.
  - LOAD: load=1, ctrl=0, busy=1.
    - Next edge: count<=0, go to SHIFT. The multiplier loads at this edge.
  - SHIFT: load=0, ctrl=1, busy=1.
    - Each edge with count<WIDTH-1: count<=count+1.
    - Edge with count==WIDTH-1: go to CAPTURE.
    - ctrl is therefore high for exactly WIDTH edges.
  - CAPTURE: load=0, ctrl=0, busy=1.
    - Next edge: product<=pq_in, done<=1, go to IDLE.
- done:
  - Registered. High for exactly the one cycle following the capture edge.
  - Cleared at the next edge unless another capture occurs.
- Latency: start sampled at edge E0; product and done visible after edge E0+WIDTH+2 (6 edges at WIDTH=4).
- Back-to-back: start=1 during the done cycle (state IDLE) is accepted at that edge. done clears at that same edge.
- start while busy=1: ignored. a_out and b_out are not modified, and the request is not queued.
- a_in/b_in changing while busy: no effect. a_out and b_out stay stable from the LOAD entry edge until the next accepted start.
- product stays stable between captures, including across ignored starts.
- Reset during LOAD, SHIFT or CAPTURE:
  - Operation abandoned; next cycle is IDLE, load=ctrl=0.
  - product=0, done=0; no partial product is captured.
- Counter never exceeds WIDTH-1 and does not wrap. count is held at 0 outside SHIFT.
- Arithmetic: the block performs none. product equals pq_in bit-exact, unsigned, 2*WIDTH bits.

Test Plan:
- Reset then idle: rst=1 for 2 edges, start=0 → load=ctrl=busy=done=0, product=0x00, a_out=b_out=0.
- Single op: a_in=3, b_in=12, start pulsed at E0 →
  - load high E0–E1; ctrl high for exactly 4 edges E1–E5.
  - done=1 only in the cycle after E6, with product=0x24.
  - busy high from E0 to E6.
- Max operands: a_in=15, b_in=15 → product=0xE1 after 6 edges; a_out=b_out=15 held throughout busy.
- Back-to-back and ignored start:
  - Start 3×12, then start again in the done cycle with 15×15 → second result 0xE1 exactly 6 edges later.
  - A start pulse held during the second operation's SHIFT with a_in=1 → ignored; a_out stays 15.
- Reset mid-operation: rst=1 on the second SHIFT edge of 15×15 →
  - Next cycle IDLE, ctrl=0, product=0x00, no done pulse.
  - A fresh 3×12 start afterwards yields 0x24.
- Zero operand: a_in=0, b_in=9 → product=0x00, done pulse, latency 6 edges.
